// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose
//   Lets instruction fetch (IF) and load/store (LS) share one memory port. It
//   picks one requester, runs a single outstanding transaction (address phase,
//   then response phase) and routes the response back to that requester.
//   addr_sel drives the datapath address mux (0 = IF address, 1 = LS address).
//   A response phase that runs past TIMEOUT_CYC cycles is aborted and flagged
//   on `timeout`.
//
// Configuration
//   MEM_ARB_RR_EN  defined   : round-robin between IF and LS on simultaneous
//                              requests. The requester not granted last wins.
//                  undefined : fixed priority, LS beats IF.
//                  A lone requester is handled the same way in both builds.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   if_req/if_addr                  IF request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata       IF accept pulse, response pulse, data
//   ls_req/ls_we/ls_be/ls_addr/
//   ls_wdata                        LS request, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata       LS accept pulse, response pulse, data
//   mem_req/mem_we/mem_be/mem_addr/
//   mem_wdata                       request to memory (address phase only)
//   mem_gnt/mem_rvalid/mem_rdata    memory accept and response
//   addr_sel                        current owner (0 = IF, 1 = LS)
//   busy                            a transaction is in flight (state != IDLE)
//   timeout                         1-cycle pulse when a response phase aborts
//
// Handshake: a requester raises req and holds its fields stable. The arbiter
// presents the owner's fields on mem_* while mem_req=1. The address phase ends
// in the cycle mem_gnt=1, and the owner's gnt pulses in that same cycle. After
// that the requester may drop or change its inputs. The response phase ends on
// the first mem_rvalid=1 (owner's rvalid pulses with mem_rdata) or on timeout.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              addr_sel,
   output logic              busy,
   output logic              timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             owner_q, owner_d;   // 0 = IF, 1 = LS
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             winner;

   // ---------------------------------------------------------------- arbiter
`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;                 // owner of the most recent grant

   always_comb begin
      if (if_req && ls_req) winner = ~last_q;
      else                  winner = ls_req;
   end

   always_comb begin
      last_d = last_q;
      if (state_q == ST_ADDR && mem_gnt) last_d = owner_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b0;
      else        last_q <= last_d;
   end
`else
   // LS wins whenever it requests, so the winner is simply ls_req.
   always_comb winner = ls_req;
`endif

   // -------------------------------------------------------------- sequencer
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (if_req || ls_req) begin
               owner_d = winner;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (mem_gnt) begin
               state_d = ST_RESP;
               cnt_d   = '0;
            end
         end
         ST_RESP: begin
            // A response in the last allowed cycle still wins over the abort.
            if (mem_rvalid || cnt_q == CNT_MAX) state_d = ST_IDLE;
            else                                cnt_d   = cnt_q + CNT_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   logic in_addr, in_resp, resp_hit;

   always_comb begin
      in_addr  = (state_q == ST_ADDR);
      in_resp  = (state_q == ST_RESP);
      // Responses outside RESP are stale (aborted or pre-reset) and dropped.
      resp_hit = in_resp && mem_rvalid;

      mem_req   = in_addr;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (in_addr) begin
         if (owner_q) begin
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
         end else begin
            mem_be    = 4'hF;
            mem_addr  = if_addr;
         end
      end

      if_gnt    = in_addr && mem_gnt && !owner_q;
      ls_gnt    = in_addr && mem_gnt &&  owner_q;
      if_rvalid = resp_hit && !owner_q;
      ls_rvalid = resp_hit &&  owner_q;
      if_rdata  = if_rvalid ? mem_rdata : '0;
      ls_rdata  = ls_rvalid ? mem_rdata : '0;

      addr_sel  = owner_q;
      busy      = (state_q != ST_IDLE);
      timeout   = in_resp && !mem_rvalid && (cnt_q == CNT_MAX);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A table of per-cycle {inputs, expected outputs}
// records covers single IF and LS transactions, a stalled address phase,
// request retraction and stale responses. Hand-written sequences cover
// arbitration order, the response timeout boundary and reset during a response.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   // ------------------------------------------------------- clock and reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        if_req, ls_req, ls_we, mem_gnt, mem_rvalid;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [3:0]  ls_be;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic        mem_req, mem_we, addr_sel, busy, timeout;
   logic [3:0]  mem_be;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .addr_sel(addr_sel), .busy(busy), .timeout(timeout)
   );

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [3:0]  ls_be;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
      logic        mem_gnt;
      logic        mem_rvalid;
      logic [31:0] mem_rdata;
   } ins_t;

   typedef struct packed {
      logic        mem_req;
      logic        mem_we;
      logic [3:0]  mem_be;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        if_gnt;
      logic        if_rvalid;
      logic [31:0] if_rdata;
      logic        ls_gnt;
      logic        ls_rvalid;
      logic [31:0] ls_rdata;
      logic        addr_sel;
      logic        busy;
      logic        timeout;
   } outs_t;

   typedef struct packed {
      ins_t  i;
      outs_t o;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------------------------------------------------- driver tasks
   task automatic drive(input ins_t i);
      if_req     = i.if_req;
      if_addr    = i.if_addr;
      ls_req     = i.ls_req;
      ls_we      = i.ls_we;
      ls_be      = i.ls_be;
      ls_addr    = i.ls_addr;
      ls_wdata   = i.ls_wdata;
      mem_gnt    = i.mem_gnt;
      mem_rvalid = i.mem_rvalid;
      mem_rdata  = i.mem_rdata;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive('0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ------------------------------------------------------------ scoreboard
   function automatic outs_t sample();
      outs_t o;
      o.mem_req   = mem_req;   o.mem_we    = mem_we;
      o.mem_be    = mem_be;    o.mem_addr  = mem_addr;
      o.mem_wdata = mem_wdata; o.if_gnt    = if_gnt;
      o.if_rvalid = if_rvalid; o.if_rdata  = if_rdata;
      o.ls_gnt    = ls_gnt;    o.ls_rvalid = ls_rvalid;
      o.ls_rdata  = ls_rdata;  o.addr_sel  = addr_sel;
      o.busy      = busy;      o.timeout   = timeout;
      return o;
   endfunction

   function automatic outs_t o_base(input logic sel, input logic bsy);
      outs_t o;
      o = '0;
      o.addr_sel = sel;
      o.busy     = bsy;
      return o;
   endfunction

   task automatic check_outs(input string name, input outs_t exp);
      outs_t act;
      act = sample();
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One IF transaction; the memory answers in RESP cycle rv_cycle
   // (-1 = never). Reports the RESP cycle index of rvalid and of timeout.
   task automatic run_resp(input int rv_cycle, output int rv_at, output int to_at);
      ins_t  i;
      outs_t e;
      rv_at = -1;
      to_at = -1;
      do_reset();
      i = '0; i.if_req = 1'b1; i.if_addr = 32'h600;
      drive(i);
      @(negedge clk);                      // ADDR
      i.mem_gnt = 1'b1;
      drive(i);
      #1;
      e = o_base(1'b0, 1'b1);
      e.mem_req = 1'b1; e.mem_be = 4'hF; e.mem_addr = 32'h600; e.if_gnt = 1'b1;
      check_outs($sformatf("resp%0d_addr", rv_cycle), e);
      @(negedge clk);                      // RESP cycle 0
      drive('0);
      for (int n = 0; n < 40; n++) begin
         if (n == rv_cycle) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h1234_5678;
         end
         #1;
         if (if_rvalid || ls_rvalid) rv_at = n;
         if (timeout) to_at = n;
         if (rv_at >= 0 || to_at >= 0) break;
         @(negedge clk);
      end
      // A late response after the transaction ended must be ignored.
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      #1;
      check_outs($sformatf("resp%0d_post", rv_cycle), o_base(1'b0, 1'b0));
   endtask

   // ------------------------------------------------------------------ test
   vec_t        vecs[$];
   logic [2:0]  exp_q[$];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t  v;
      ins_t  ld;
      outs_t oa;
      int    rv_at, to_at;

      // Vector table, one record per clock cycle, starting right after reset.
      v = '0; v.i.if_req = 1; v.i.if_addr = 32'h100; v.o = o_base(0, 0); vecs.push_back(v);
      v.i.mem_gnt = 1; v.o = o_base(0, 1);
      v.o.mem_req = 1; v.o.mem_be = 4'hF; v.o.mem_addr = 32'h100; v.o.if_gnt = 1;
      vecs.push_back(v);
      v = '0; v.i.mem_rvalid = 1; v.i.mem_rdata = 32'h13; v.o = o_base(0, 1);
      v.o.if_rvalid = 1; v.o.if_rdata = 32'h13; vecs.push_back(v);
      v = '0; v.o = o_base(0, 0); vecs.push_back(v);
      // LS store
      v = '0; v.i.ls_req = 1; v.i.ls_we = 1; v.i.ls_be = 4'b0011;
      v.i.ls_addr = 32'h200; v.i.ls_wdata = 32'hDEAD_BEEF; v.o = o_base(0, 0);
      vecs.push_back(v);
      v.i.mem_gnt = 1; v.o = o_base(1, 1);
      v.o.mem_req = 1; v.o.mem_we = 1; v.o.mem_be = 4'b0011; v.o.mem_addr = 32'h200;
      v.o.mem_wdata = 32'hDEAD_BEEF; v.o.ls_gnt = 1; vecs.push_back(v);
      v = '0; v.i.mem_rvalid = 1; v.i.mem_rdata = 32'h55; v.o = o_base(1, 1);
      v.o.ls_rvalid = 1; v.o.ls_rdata = 32'h55; vecs.push_back(v);
      // stale response while idle
      v = '0; v.i.mem_rvalid = 1; v.i.mem_rdata = 32'hAA; v.o = o_base(1, 0); vecs.push_back(v);
      // LS load with 5 stalled address cycles, then retracted req at grant
      ld = '0; ld.ls_req = 1; ld.ls_be = 4'hF; ld.ls_addr = 32'h300; ld.ls_wdata = 32'h1234;
      v = '0; v.i = ld; v.o = o_base(1, 0); vecs.push_back(v);
      for (int k = 0; k < 5; k++) begin
         v = '0; v.i = ld;
         if (k == 1) begin v.i.mem_rvalid = 1; v.i.mem_rdata = 32'h77; end
         v.o = o_base(1, 1); v.o.mem_req = 1; v.o.mem_be = 4'hF;
         v.o.mem_addr = 32'h300; v.o.mem_wdata = 32'h1234;
         vecs.push_back(v);
      end
      v.i = ld; v.i.ls_req = 0; v.i.mem_gnt = 1; v.o.ls_gnt = 1; vecs.push_back(v);
      v = '0; v.o = o_base(1, 1); vecs.push_back(v);
      v = '0; v.i.mem_rvalid = 1; v.i.mem_rdata = 32'hCAFE_F00D; v.o = o_base(1, 1);
      v.o.ls_rvalid = 1; v.o.ls_rdata = 32'hCAFE_F00D; vecs.push_back(v);
      v = '0; v.o = o_base(1, 0); vecs.push_back(v);
      // IF after LS: ownership returns to IF
      v = '0; v.i.if_req = 1; v.i.if_addr = 32'h104; v.o = o_base(1, 0); vecs.push_back(v);
      v.i.mem_gnt = 1; v.o = o_base(0, 1);
      v.o.mem_req = 1; v.o.mem_be = 4'hF; v.o.mem_addr = 32'h104; v.o.if_gnt = 1;
      vecs.push_back(v);
      v = '0; v.i.mem_rvalid = 1; v.i.mem_rdata = 32'h0040_0093; v.o = o_base(0, 1);
      v.o.if_rvalid = 1; v.o.if_rdata = 32'h0040_0093; vecs.push_back(v);
      v = '0; v.o = o_base(0, 0); vecs.push_back(v);

      // Reset: outputs stay quiet even with every input active.
      v = '0;
      v.i.if_req = 1; v.i.ls_req = 1; v.i.mem_gnt = 1; v.i.mem_rvalid = 1;
      v.i.mem_rdata = 32'hFFFF_FFFF;
      drive(v.i);
      repeat (2) @(negedge clk);
      #1;
      check_outs("reset_hold", o_base(0, 0));
      drive('0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k].i);
         #1;
         check_outs($sformatf("vec%0d", k), vecs[k].o);
      end

      // Both requesters held through four transactions.
      do_reset();
`ifdef MEM_ARB_RR_EN
      exp_q = '{3'b011, 3'b100, 3'b011, 3'b100};
`else
      exp_q = '{3'b011, 3'b011, 3'b011, 3'b011};
`endif
      v = '0;
      v.i.if_req = 1; v.i.if_addr = 32'h400;
      v.i.ls_req = 1; v.i.ls_be = 4'hF; v.i.ls_addr = 32'h500;
      v.i.mem_gnt = 1; v.i.mem_rvalid = 1; v.i.mem_rdata = 32'h99;
      drive(v.i);
      for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
         @(negedge clk);
         #1;
         if (if_gnt || ls_gnt) begin
            logic [2:0] got, exp;
            got = {if_gnt, ls_gnt, addr_sel};
            exp = exp_q.pop_front();
            n_tests++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL arb_order: got %b expected %b (if_gnt,ls_gnt,addr_sel)", got, exp);
            end
         end
      end
      check_int("arb_grants_left", exp_q.size(), 0);

      // Response timeout boundary.
      run_resp(-1, rv_at, to_at);
      check_int("timeout_cycle", to_at, 16);
      check_int("timeout_no_rvalid", rv_at, -1);
      run_resp(16, rv_at, to_at);
      check_int("last_cycle_rvalid", rv_at, 16);
      check_int("last_cycle_no_timeout", to_at, -1);
      run_resp(3, rv_at, to_at);
      check_int("early_rvalid", rv_at, 3);
      check_int("early_no_timeout", to_at, -1);

      // Reset asserted during RESP with a response on the bus.
      do_reset();
      v = '0; v.i.ls_req = 1; v.i.ls_be = 4'hF; v.i.ls_addr = 32'h700;
      drive(v.i);
      @(negedge clk);
      mem_gnt = 1'b1;
      @(negedge clk);
      drive('0);
      #1;
      check_outs("rst_mid_resp_busy", o_base(1, 1));
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_0000;
      #1;
      rst_n = 1'b0;
      #1;
      oa = o_base(0, 0);
      check_outs("rst_mid_async", oa);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check_outs($sformatf("rst_after%0d", c), oa);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
